// File: rtl/pwm_generator.sv
// pwm_generator: drives 16 registered output pins. Each pin is forced low,
// held high, or driven by one shared 8-bit PWM waveform. The waveform is
// clocked by a prescaler that produces one tick every CLK_DIV clk cycles.
//
// Optional feature macro: PWM_SHADOW_DUTY_EN
//   defined   - the duty value is captured into a shadow register at each
//               period boundary, so a duty write never truncates a pulse.
//   undefined - the live pwm_duty_cycle input is compared directly, and a
//               change applies on the next clk.
//
// All inputs are synchronous to clk. The SPI register file shares this
// clock domain, so the inputs need no synchronizer.
module pwm_generator #(
    parameter int CLK_DIV = 3000  // clk cycles per PWM tick, legal range 1..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] pre;
    logic [7:0]  cnt;
    logic        tick;
    logic        wrap;
    logic [7:0]  duty_act;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] out_nxt;

    assign tick   = (pre == DIV_LAST);
    assign wrap   = tick && (cnt == 8'hFF);
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler: count 0..CLK_DIV-1, then wrap. With CLK_DIV=1 it stays at 0
    // and tick is asserted every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= 16'd0;
        end else if (tick) begin
            pre <= 16'd0;
        end else begin
            pre <= pre + 16'd1;
        end
    end

    // PWM counter: advance once per tick. It wraps 255 -> 0 with no hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Period marker: high for the single cycle in which cnt has just become 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

`ifdef PWM_SHADOW_DUTY_EN
    logic [7:0] duty_shadow;

    // Shadow duty: capture the live input only on the wrap edge, so every
    // period runs with a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= 8'd0;
        end else if (wrap) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    assign duty_act = duty_shadow;
`else
    assign duty_act = pwm_duty_cycle;
`endif

    // 0xFF is special-cased so the output is fully high, not 255/256.
    assign pwm_sig = (duty_act == 8'hFF) | (cnt < duty_act);

    // Per-pin select. A disabled pin is low whatever its PWM bit is. An
    // enabled pin is high, or follows pwm_sig when it is in PWM mode.
    always_comb begin
        out_nxt = en_out & (~en_pwm | {16{pwm_sig}});
    end

    // Output register: every pin updates on the same edge. PWM pins stay
    // phase-aligned, and a change to both enables at once shows only the
    // new pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 16'h0000;
        end else begin
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed test of pwm_generator. The main instance uses
// CLK_DIV=4 and a second instance uses CLK_DIV=1. Both instances share their
// inputs.
module tb_pwm_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = 8'hFF;
    logic [7:0]  en_reg_out_15_8 = 8'hFF;
    logic [7:0]  en_reg_pwm_7_0 = 8'hFF;
    logic [7:0]  en_reg_pwm_15_8 = 8'hFF;
    logic [7:0]  pwm_duty_cycle = 8'h80;
    logic [15:0] out4;
    logic        ps4;
    logic [15:0] out1;
    logic        ps1;

    int checks = 0;
    int failures = 0;

    // Clock generation: 10 time-unit period.
    always #5 clk = ~clk;

    pwm_generator #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .out(out4), .period_start(ps4)
    );

    pwm_generator #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .out(out1), .period_start(ps1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
    endtask

    // Count negedges until period_start of the chosen instance is seen.
    // The count stops at the limit if the pulse never comes.
    task automatic wait_ps(input int which, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if ((which == 4) ? ps4 : ps1) break;
        end
    endtask

    // Sample n negedges. high counts samples where every masked bit is 1.
    // mixed counts samples where the masked bits are neither all 0 nor all 1.
    task automatic count_high(input int which, input int n, input logic [15:0] mask,
                              output int high, output int mixed);
        logic [15:0] o;
        high = 0;
        mixed = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = ((which == 4) ? out4 : out1) & mask;
            if (o == mask) high++;
            else if (o != 16'h0000) mixed++;
        end
    endtask

    // Count the samples where (out4 & mask) differs from val.
    task automatic count_ne(input int n, input logic [15:0] mask, input logic [15:0] val,
                            output int ne);
        ne = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ((out4 & mask) != val) ne++;
        end
    endtask

    initial begin
        int cyc;
        int hi;
        int mx;
        int bad;
        logic [7:0] duties[4];
        int exp_hi[4];
        duties = '{8'h00, 8'h01, 8'h80, 8'hFF};
        exp_hi = '{0, 4, 512, 1024};

        // Reset held with all enables 0xFF and duty 0x80.
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out4 !== 16'h0000 || ps4 !== 1'b0 || out1 !== 16'h0000 || ps1 !== 1'b0) bad++;
        end
        check("reset_hold_outputs_low", bad, 0);
        rst_n = 1'b1;
        wait_ps(4, 2000, cyc);
        check("first_period_start_latency", cyc, 1024);
        @(negedge clk);
        check("period_start_one_cycle", ps4, 0);

        // Duty sweep at CLK_DIV=4 with all pins in PWM mode. After each duty
        // write, wait for a boundary, then sample one full 1024-cycle period.
        for (int k = 0; k < 4; k++) begin
            pwm_duty_cycle = duties[k];
            wait_ps(4, 2100, cyc);
            count_high(4, 1024, 16'hFFFF, hi, mx);
            check($sformatf("sweep_high_duty_%0h", duties[k]), hi, exp_hi[k]);
            check($sformatf("sweep_phase_aligned_%0h", duties[k]), mx, 0);
        end

        // Static modes: pins 7..0 held high, pins 15..8 off.
        pwm_duty_cycle = 8'h80;
        set_en(16'h00FF, 16'h0000);
        @(negedge clk);
        check("static_one_cycle_latency", out4, 16'h00FF);
        count_ne(3072, 16'hFFFF, 16'h00FF, bad);
        check("static_constant_3_periods", bad, 0);

        // Enable changes mid-period: upper byte goes to PWM, lower byte stays high.
        set_en(16'hFFFF, 16'hFF00);
        count_ne(1024, 16'h00FF, 16'h00FF, bad);
        check("mixed_low_byte_held_high", bad, 0);
        count_high(4, 1024, 16'hFF00, hi, mx);
        check("mixed_high_byte_pwm_high", hi, 512);
        check("mixed_high_byte_aligned", mx, 0);

        // Duty change 0x40 -> 0xC0 at cnt=100.
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        wait_ps(4, 2100, cyc);
        wait_ps(4, 2100, cyc);
        repeat (400) @(negedge clk);
        check("midchange_low_before", out4, 16'h0000);
        pwm_duty_cycle = 8'hC0;
        @(negedge clk);
`ifdef PWM_SHADOW_DUTY_EN
        check("midchange_next_clk", out4, 16'h0000);
`else
        check("midchange_next_clk", out4, 16'hFFFF);
`endif
        wait_ps(4, 2100, cyc);
        count_high(4, 1024, 16'hFFFF, hi, mx);
        check("midchange_next_period_high", hi, 768);

        // Prescale edge case on the CLK_DIV=1 instance.
        pwm_duty_cycle = 8'h10;
        wait_ps(1, 600, cyc);
        count_high(1, 256, 16'hFFFF, hi, mx);
        check("div1_duty10_high", hi, 16);
        wait_ps(1, 600, cyc);
        wait_ps(1, 600, cyc);
        check("div1_period_start_spacing", cyc, 256);

        // Reset mid-operation at cnt=200, with all pins held high.
        set_en(16'hFFFF, 16'h0000);
        wait_ps(4, 2100, cyc);
        repeat (800) @(negedge clk);
        check("midreset_out_high_before", out4, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        check("midreset_async_clear", out4, 16'h0000);
        repeat (3) @(negedge clk);
        check("midreset_held_clear", {ps4, out4}, 17'h0);
        rst_n = 1'b1;
        wait_ps(4, 2000, cyc);
        check("midreset_restart_latency", cyc, 1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
